conv_encoder_k3: RTL and testbench



---
 rtl/conv_encoder_k3_if.sv | 13 +
 rtl/conv_encoder_k3.sv | 122 ++++++++++++
 tb/tb_conv_encoder_k3.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_encoder_k3_if.sv
// Valid/ready stream carrying a W-bit payload plus an end-of-frame marker.
// master drives payload and valid; slave returns ready.
interface conv_encoder_k3_if #(
    parameter int W = 1
);
    logic         vld;
    logic         rdy;
    logic [W-1:0] dat;
    logic         last;

    modport master (output vld, output dat, output last, input  rdy);
    modport slave  (input  vld, input  dat, input  last, output rdy);
endinterface

// File: rtl/conv_encoder_k3.sv
// Rate-1/2 feed-forward convolutional encoder, K-1 zero tail symbols per frame; 1-cycle latency,
// single output register, input stalls when the slot is full or tail is draining. Option: CONV_ENC_PUNCTURE_EN.
module conv_encoder_k3 #(
    parameter int           K  = 3,
    parameter logic [K-1:0] G0 = 3'b111,
    parameter logic [K-1:0] G1 = 3'b101
) (
    input  logic                     clk,
    input  logic                     rst_n,
    conv_encoder_k3_if.slave         i_in,
    conv_encoder_k3_if.master        o_out,
    output logic                     o_busy
`ifdef CONV_ENC_PUNCTURE_EN
    ,
    output logic [1:0]               o_out_mask
`endif
);
    localparam int CW = (K > 2) ? $clog2(K) : 1;

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_TAIL} state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [K-2:0]  r_sr;
    logic [CW-1:0] r_tail_cnt;
    logic          r_vld;
    logic          r_last;
    logic [1:0]    r_sym;

    logic          w_slot_free;
    logic          w_in_rdy;
    logic          w_acc;
    logic          w_tail_step;
    logic          w_tail_end;
    logic          w_enc_bit;
    logic [K-1:0]  w_win;
    logic [1:0]    w_sym;

    assign w_slot_free = !r_vld || o_out.rdy;
    assign w_tail_end  = w_tail_step && (r_tail_cnt == CW'(1));
    assign w_enc_bit   = (r_state == S_TAIL) ? 1'b0 : i_in.dat[0];
    assign w_win       = {r_sr, w_enc_bit};
    assign w_sym       = {^(G1 & w_win), ^(G0 & w_win)};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_acc) w_state_nxt = i_in.last ? S_TAIL : S_DATA;
            S_DATA: if (w_acc && i_in.last) w_state_nxt = S_TAIL;
            S_TAIL: if (w_tail_end) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // in_ready is forced low during reset so no input can be taken while rst_n is held.
    always_comb begin
        w_in_rdy    = rst_n && w_slot_free && (r_state != S_TAIL);
        w_acc       = i_in.vld && w_in_rdy;
        w_tail_step = (r_state == S_TAIL) && w_slot_free;
        o_busy      = (r_state != S_IDLE) || r_vld;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sr       <= '0;
            r_tail_cnt <= '0;
            r_vld      <= 1'b0;
            r_last     <= 1'b0;
            r_sym      <= 2'b00;
        end else begin
            if (w_acc || w_tail_step) begin
                r_sym  <= w_sym;
                r_vld  <= 1'b1;
                r_last <= w_tail_end;
                r_sr   <= w_win[K-2:0];
            end else if (w_slot_free) begin
                r_vld  <= 1'b0;
                r_last <= 1'b0;
            end

            if (w_acc && i_in.last) begin
                r_tail_cnt <= CW'(K - 1);
            end else if (w_tail_step) begin
                r_tail_cnt <= r_tail_cnt - CW'(1);
            end
        end
    end

`ifdef CONV_ENC_PUNCTURE_EN
    // Phase tracks the data-symbol index within the frame; symbols leave in order, so
    // toggling on load matches toggling on transfer.
    logic       r_phase;
    logic [1:0] r_mask;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase <= 1'b0;
            r_mask  <= 2'b00;
        end else if (w_acc) begin
            r_mask  <= ((r_state == S_IDLE) || !r_phase) ? 2'b11 : 2'b01;
            r_phase <= (r_state == S_IDLE) ? 1'b1 : ~r_phase;
        end else if (w_tail_step) begin
            r_mask  <= 2'b11;
        end
    end

    assign o_out_mask = r_mask;
`endif

    assign i_in.rdy   = w_in_rdy;
    assign o_out.vld  = r_vld;
    assign o_out.dat  = r_sym;
    assign o_out.last = r_last;
endmodule

// File: tb/tb_conv_encoder_k3.sv
// Scoreboard bench for conv_encoder_k3: directed frames push hand-computed symbols,
// a negedge monitor pops and compares on every output transfer.
module tb_conv_encoder_k3;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy;

    always #5 clk = ~clk;

    conv_encoder_k3_if #(.W(1)) in_if();
    conv_encoder_k3_if #(.W(2)) out_if();

`ifdef CONV_ENC_PUNCTURE_EN
    logic [1:0] out_mask;
`endif

    conv_encoder_k3 dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_in   (in_if),
        .o_out  (out_if),
        .o_busy (busy)
`ifdef CONV_ENC_PUNCTURE_EN
        ,
        .o_out_mask (out_mask)
`endif
    );

    typedef struct packed {
        logic [1:0] sym;
        logic       last;
        logic [1:0] mask;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   checks = 0;
    int   failures = 0;

    logic       bp_en = 1'b0;
    logic [3:0] bp_pat = 4'b1001;
    int         bp_idx = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic expect_sym(input logic [1:0] s, input logic l, input logic [1:0] m);
        exp_t t;
        t.sym = s; t.last = l; t.mask = m;
        q.push_back(t);
    endtask

    // Downstream ready: constant 1, or the repeating 1,0,0,1 stall pattern.
    always @(posedge clk) begin
        #1;
        if (bp_en) begin
            out_if.rdy = bp_pat[bp_idx % 4];
            bp_idx++;
        end else begin
            out_if.rdy = 1'b1;
        end
    end

    logic       held = 1'b0;
    logic [1:0] held_sym;
    logic       held_last;

    always @(negedge clk) begin
        if (rst_n) begin
            if (held && out_if.vld) begin
                chk("hold_sym", 32'(out_if.dat), 32'(held_sym));
                chk("hold_last", 32'(out_if.last), 32'(held_last));
            end
            if (out_if.vld && out_if.rdy) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_symbol actual=%b required=none", out_if.dat);
                end else begin
                    e = q.pop_front();
                    chk("sym", 32'(out_if.dat), 32'(e.sym));
                    chk("last", 32'(out_if.last), 32'(e.last));
`ifdef CONV_ENC_PUNCTURE_EN
                    chk("mask", 32'(out_mask), 32'(e.mask));
`endif
                end
                held = 1'b0;
            end else if (out_if.vld) begin
                chk("stall_in_ready", 32'(in_if.rdy), 32'd0);
                held      = 1'b1;
                held_sym  = out_if.dat;
                held_last = out_if.last;
            end else begin
                held = 1'b0;
            end
        end else begin
            held = 1'b0;
        end
    end

    task automatic send(input logic b, input logic l, output logic saw_last);
        int   n;
        logic acc;
        n = 0;
        saw_last = 1'b0;
        in_if.vld  = 1'b1;
        in_if.dat  = b;
        in_if.last = l;
        forever begin
            @(negedge clk);
            acc      = in_if.rdy;
            saw_last = out_if.vld && out_if.last && out_if.rdy;
            @(posedge clk);
            #1;
            if (acc) break;
            n++;
            if (n > 40) begin
                checks++;
                failures++;
                $display("FAIL accept_timeout actual=no_accept required=accept");
                break;
            end
        end
        in_if.vld = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_drained"}, 32'(q.size()), 32'd0);
        @(posedge clk);
        #1;
        chk({name, "_busy_low"}, 32'(busy), 32'd0);
    endtask

    // Frame 1,0,1,1 -> data 11,01,00,10 then tail 10,11.
    task automatic frame_1011(input string name);
        logic s;
        expect_sym(2'b11, 1'b0, 2'b11);
        expect_sym(2'b01, 1'b0, 2'b01);
        expect_sym(2'b00, 1'b0, 2'b11);
        expect_sym(2'b10, 1'b0, 2'b01);
        expect_sym(2'b10, 1'b0, 2'b11);
        expect_sym(2'b11, 1'b1, 2'b11);
        send(1'b1, 1'b0, s);
        chk({name, "_busy_mid"}, 32'(busy), 32'd1);
        send(1'b0, 1'b0, s);
        send(1'b1, 1'b0, s);
        send(1'b1, 1'b1, s);
        drain(name);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic s;
        in_if.vld  = 1'b0;
        in_if.dat  = 1'b0;
        in_if.last = 1'b0;

        #2;
        chk("rst_out_valid", 32'(out_if.vld), 32'd0);
        chk("rst_out_sym", 32'(out_if.dat), 32'd0);
        chk("rst_out_last", 32'(out_if.last), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        #10;
        chk("rst_in_ready", 32'(in_if.rdy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        frame_1011("t1");

        expect_sym(2'b11, 1'b0, 2'b11);
        expect_sym(2'b01, 1'b0, 2'b11);
        expect_sym(2'b11, 1'b1, 2'b11);
        send(1'b1, 1'b1, s);
        @(negedge clk);
        chk("t2_tail_rdy0", 32'(in_if.rdy), 32'd0);
        @(negedge clk);
        chk("t2_tail_rdy1", 32'(in_if.rdy), 32'd0);
        @(negedge clk);
        chk("t2_post_tail_rdy", 32'(in_if.rdy), 32'd1);
        drain("t2");

        bp_en = 1'b1;
        frame_1011("t3");
        bp_en = 1'b0;
        @(posedge clk);
        #1;

        expect_sym(2'b11, 1'b0, 2'b11);
        expect_sym(2'b01, 1'b0, 2'b11);
        expect_sym(2'b11, 1'b1, 2'b11);
        expect_sym(2'b11, 1'b0, 2'b11);
        expect_sym(2'b01, 1'b0, 2'b11);
        expect_sym(2'b11, 1'b1, 2'b11);
        send(1'b1, 1'b1, s);
        send(1'b1, 1'b1, s);
        chk("t4_b2b_overlap", 32'(s), 32'd1);
        drain("t4");

        expect_sym(2'b11, 1'b0, 2'b11);
        expect_sym(2'b01, 1'b0, 2'b01);
        send(1'b1, 1'b0, s);
        send(1'b0, 1'b0, s);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_out_valid", 32'(out_if.vld), 32'd0);
        chk("t5_rst_out_sym", 32'(out_if.dat), 32'd0);
        chk("t5_rst_out_last", 32'(out_if.last), 32'd0);
        chk("t5_rst_busy", 32'(busy), 32'd0);
        chk("t5_rst_in_ready", 32'(in_if.rdy), 32'd0);
        q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        // Frame 1,0: data 11,01 then tail from sr=(b1=1,b0=0): 11, then 00.
        expect_sym(2'b11, 1'b0, 2'b11);
        expect_sym(2'b01, 1'b0, 2'b01);
        expect_sym(2'b11, 1'b0, 2'b11);
        expect_sym(2'b00, 1'b1, 2'b11);
        send(1'b1, 1'b0, s);
        send(1'b0, 1'b1, s);
        drain("t5");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
